// File: rtl/instr_mem_ctrl.sv
// Byte-addressed instruction memory with a byte-wide load port and a valid/ready fetch port
// that returns INSTR_W-bit big-endian instructions. Define IMEM_ALIGN_CHECK_EN to flag misaligned pc.
module instr_mem_ctrl #(
  parameter int unsigned INSTR_W     = 16,
  parameter int unsigned DEPTH_BYTES = 512,
  parameter int unsigned ADDR_W      = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [ADDR_W-1:0]  pc,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [INSTR_W-1:0] ins,
  output logic               rsp_err,
  input  logic               ld_en,
  input  logic [ADDR_W-1:0]  ld_addr,
  input  logic [7:0]         ld_data,
  output logic               busy
);

  localparam int unsigned NumBytes = INSTR_W / 8;
  localparam int unsigned MemAw    = (DEPTH_BYTES > 1) ? $clog2(DEPTH_BYTES) : 1;

  typedef enum logic [1:0] {StIdle, StResp, StLoad} state_e;

  state_e             state_q, state_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [INSTR_W-1:0] ins_q, ins_d;
  logic               rsp_err_q, rsp_err_d;
  logic               rdy_en_q;

  logic [7:0]         mem_q [DEPTH_BYTES];

  logic [INSTR_W-1:0] fetch_data;
  logic               fetch_err;
  logic [63:0]        last_addr;
  logic [63:0]        byte_addr;
  logic [63:0]        ld_idx;
  logic               ld_we;
  logic               accept;

  // Read path: assemble bytes pc..pc+NumBytes-1, most significant first; no wrap-around.
  always_comb begin
    fetch_data = '0;
    byte_addr  = '0;
    last_addr  = 64'(pc) + 64'(NumBytes - 1);
    fetch_err  = (last_addr >= 64'(DEPTH_BYTES));
`ifdef IMEM_ALIGN_CHECK_EN
    if ((64'(pc) % 64'(NumBytes)) != 64'd0) begin
      fetch_err = 1'b1;
    end
`endif
    for (int unsigned i = 0; i < NumBytes; i++) begin
      byte_addr = 64'(pc) + 64'(i);
      if (byte_addr < 64'(DEPTH_BYTES)) begin
        fetch_data[INSTR_W-1-8*i -: 8] = mem_q[byte_addr[MemAw-1:0]];
      end
    end
    if (fetch_err) begin
      fetch_data = '0;
    end
  end

  // Loads are only honoured outside RESP so a pending response never races a write.
  assign ld_idx = 64'(ld_addr);
  assign ld_we  = ld_en && (state_q != StResp) && (ld_idx < 64'(DEPTH_BYTES));

  always_ff @(posedge clk) begin
    if (ld_we) begin
      mem_q[ld_idx[MemAw-1:0]] <= ld_data;
    end
  end

  // rdy_en_q keeps req_ready low until the first clock edge after reset release.
  assign req_ready = rdy_en_q && !ld_en &&
                     ((state_q == StIdle) || ((state_q == StResp) && rsp_ready));
  assign accept    = req_valid && req_ready;

  always_comb begin
    state_d     = state_q;
    rsp_valid_d = rsp_valid_q;
    ins_d       = ins_q;
    rsp_err_d   = rsp_err_q;
    unique case (state_q)
      StIdle: begin
        if (ld_en) begin
          state_d = StLoad;
        end else if (accept) begin
          state_d     = StResp;
          rsp_valid_d = 1'b1;
          ins_d       = fetch_data;
          rsp_err_d   = fetch_err;
        end
      end
      StLoad: begin
        if (!ld_en) begin
          state_d = StIdle;
        end
      end
      StResp: begin
        if (rsp_ready) begin
          if (accept) begin
            rsp_valid_d = 1'b1;
            ins_d       = fetch_data;
            rsp_err_d   = fetch_err;
          end else begin
            state_d     = StIdle;
            rsp_valid_d = 1'b0;
          end
        end
      end
      default: begin
        state_d     = StIdle;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      rsp_valid_q <= 1'b0;
      ins_q       <= '0;
      rsp_err_q   <= 1'b0;
      rdy_en_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      rsp_valid_q <= rsp_valid_d;
      ins_q       <= ins_d;
      rsp_err_q   <= rsp_err_d;
      rdy_en_q    <= 1'b1;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign ins       = ins_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_instr_mem_ctrl.sv
// Bench for instr_mem_ctrl: directed scenarios plus randomized loads/fetches against a byte-array model.
module tb_instr_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [15:0] pc;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] ins;
  logic        rsp_err;
  logic        ld_en;
  logic [15:0] ld_addr;
  logic [7:0]  ld_data;
  logic        busy;

  int unsigned total = 0;
  int unsigned bad   = 0;
  logic [7:0]  mm [512];
  logic        pending = 1'b0;

  always #5 clk = ~clk;

  instr_mem_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .pc        (pc),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .ins       (ins),
    .rsp_err   (rsp_err),
    .ld_en     (ld_en),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data),
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected response for a fetch at address a: two bytes big-endian, error past the end.
  task automatic model(input logic [15:0] a, output logic [15:0] ei, output logic ee);
    int unsigned ai;
    ai = a;
    ee = (ai + 1 >= 512);
`ifdef IMEM_ALIGN_CHECK_EN
    if (ai % 2 != 0) ee = 1'b1;
`endif
    ei = ee ? 16'h0 : {mm[ai], mm[ai+1]};
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue a fetch (consuming any pending response in the same cycle), then hold for 'hold' cycles.
  task automatic fetch(input logic [15:0] a, input int hold);
    logic [15:0] ei;
    logic        ee;
    int          n;
    model(a, ei, ee);
    req_valid = 1'b1;
    pc        = a;
    rsp_ready = 1'b1;
    #1;
    n = 0;
    while (req_ready !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    if (n >= 20) chk("accept_timeout", {31'd0, req_ready}, 32'd1);
    step();
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    pending   = 1'b1;
    chk("rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("rsp_ins", {16'd0, ins}, {16'd0, ei});
    chk("rsp_err", {31'd0, rsp_err}, {31'd0, ee});
    for (int k = 0; k < hold; k++) begin
      step();
      chk("hold_valid", {31'd0, rsp_valid}, 32'd1);
      chk("hold_ins", {16'd0, ins}, {16'd0, ei});
      chk("hold_req_ready", {31'd0, req_ready}, 32'd0);
    end
  endtask

  task automatic consume();
    rsp_ready = 1'b1;
    req_valid = 1'b0;
    step();
    rsp_ready = 1'b0;
    pending   = 1'b0;
    chk("consumed", {31'd0, rsp_valid}, 32'd0);
  endtask

  task automatic ld_byte(input logic [15:0] a, input logic [7:0] d);
    ld_en   = 1'b1;
    ld_addr = a;
    ld_data = d;
    step();
    if (a < 16'd512) mm[a] = d;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_err", {31'd0, rsp_err}, 32'd0);
    chk("rst_ins", {16'd0, ins}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
    pending = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    #1;
    chk("post_rst_ready_early", {31'd0, req_ready}, 32'd0);
    step();
    chk("post_rst_ready", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b0;
  endtask

  initial begin
    logic [15:0] a;
    logic [7:0]  old4;
    rst_n = 1'b0; req_valid = 1'b1; pc = '0; rsp_ready = 1'b0;
    ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    #2;
    do_reset();

    // Fill the whole memory, then one out-of-range byte that must be dropped.
    for (int i = 0; i < 512; i++) ld_byte(16'(i), 8'($urandom));
    chk("load_busy", {31'd0, busy}, 32'd1);
    ld_byte(16'd600, 8'hEE);
    ld_byte(16'd0, 8'h12);
    ld_byte(16'd1, 8'h34);
    ld_byte(16'd2, 8'h56);
    ld_en = 1'b0;
    step();
    chk("idle_busy", {31'd0, busy}, 32'd0);
    chk("idle_no_rsp", {31'd0, rsp_valid}, 32'd0);

    fetch(16'd0, 0);
    chk("basic_ins", {16'd0, ins}, 32'h1234);

    // Backpressure with a competing request, then back-to-back acceptance.
    req_valid = 1'b1; pc = 16'd2;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("bp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("bp_ins", {16'd0, ins}, 32'h1234);
      chk("bp_err", {31'd0, rsp_err}, 32'd0);
      chk("bp_req_ready", {31'd0, req_ready}, 32'd0);
    end
    rsp_ready = 1'b1;
    #1;
    chk("b2b_ready", {31'd0, req_ready}, 32'd1);
    fetch(16'd2, 0);

    fetch(16'd511, 0);
    chk("oob_err", {31'd0, rsp_err}, 32'd1);
    fetch(16'd510, 0);
    chk("edge_ok", {31'd0, rsp_err}, 32'd0);
    fetch(16'd1, 1);
    consume();

    // Load attempted while a response is pending is ignored.
    old4 = mm[4];
    fetch(16'd4, 0);
    ld_en = 1'b1; ld_addr = 16'd4; ld_data = ~old4;
    step();
    step();
    chk("ld_in_resp_valid", {31'd0, rsp_valid}, 32'd1);
    ld_en = 1'b0;
    consume();
    fetch(16'd4, 0);
    chk("ld_in_resp_nowrite", {16'd0, ins}, {16'd0, old4, mm[5]});
    consume();

    // Load wins over a simultaneous request.
    ld_en = 1'b1; ld_addr = 16'd6; ld_data = 8'hA5; req_valid = 1'b1; pc = 16'd6;
    #1;
    chk("ld_wins_ready", {31'd0, req_ready}, 32'd0);
    step();
    mm[6] = 8'hA5;
    chk("ld_wins_busy", {31'd0, busy}, 32'd1);
    ld_en = 1'b0;
    fetch(16'd6, 0);
    chk("ld_wins_data", {24'd0, ins[15:8]}, 32'hA5);

    // Asynchronous reset drops a pending response; memory survives.
    fetch(16'd0, 0);
    do_reset();
    fetch(16'd0, 0);
    consume();

    // Randomized mix of load bursts and fetches with random backpressure.
    for (int it = 0; it < 80; it++) begin
      if ($urandom_range(0, 3) == 0) begin
        if (pending) consume();
        for (int b = 0; b < int'($urandom_range(1, 3)); b++) begin
          a = ($urandom_range(0, 9) == 0) ? 16'($urandom_range(512, 700))
                                           : 16'($urandom_range(0, 511));
          ld_byte(a, 8'($urandom));
        end
        ld_en = 1'b0;
      end else begin
        a = ($urandom_range(0, 5) == 0) ? 16'($urandom_range(505, 515))
                                         : 16'($urandom_range(0, 511));
        fetch(a, int'($urandom_range(0, 2)));
      end
    end
    if (pending) consume();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
